// File: rtl/ram_dual_stream_ctrl.sv
// Word-in / halfword-out stream buffer that sequences one ram_dual instance.
// Producer words are written whole; the consumer receives the high half first,
// then the low half. A halfword currently held in out_data is not counted in level.
module ram_dual_stream_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH/2-1:0]   out_data,
    output logic [DEPTH+1:0]     level,
    output logic                 ram_wr_en,
    output logic [WIDTH-1:0]     ram_din,
    output logic [DEPTH-1:0]     ram_writeAddr,
    output logic [DEPTH:0]       ram_readAddr,
    input  logic [WIDTH/2-1:0]   ram_dout
);

    // Highest level at which a full word (two halfwords) still fits.
    localparam logic [DEPTH+1:0] WrLimit = {1'b0, {DEPTH{1'b1}}, 1'b0};

    typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

    state_e               state_q;
    logic [DEPTH-1:0]     wptr_q, wptr_d;
    logic [DEPTH:0]       rptr_q, rptr_d;
    logic [DEPTH+1:0]     count_q, count_d;
    logic                 out_valid_q;
    logic [WIDTH/2-1:0]   out_data_q;
    logic                 wr;
    logic                 issue;

    assign in_ready      = ~reset & ~flush & (count_q <= WrLimit);
    assign ram_wr_en     = wr;
    assign ram_din       = in_data;
    assign ram_writeAddr = wptr_q;
    assign ram_readAddr  = rptr_q;
    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign level         = count_q;

    // Handshakes, read issue decision and next pointer/level values.
    // Issue looks only at the registered count, so a read never hits the word
    // being written in the same cycle.
    always_comb begin
        wr     = in_valid & in_ready;
        issue  = 1'b0;
        if (count_q != '0) begin
            if (state_q == StIdle) begin
                issue = 1'b1;
            end else if (state_q == StHold && out_ready) begin
                issue = 1'b1;
            end
        end
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr) begin
            wptr_d  = wptr_q + 1'b1;
            count_d = count_d + 2'd2;
        end
        if (issue) begin
            rptr_d  = rptr_q + 1'b1;
            count_d = count_d - 1'b1;
        end
    end

    // State update: reset clears everything, flush clears all but out_data,
    // otherwise advance pointers and the read FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (flush) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            unique case (state_q)
                StIdle: begin
                    if (issue) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    out_data_q  <= ram_dout;
                    out_valid_q <= 1'b1;
                    state_q     <= StHold;
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= issue ? StWait : StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dual_stream_ctrl.sv
// Directed bench for ram_dual_stream_ctrl with a behavioural ram_dual alongside.
module tb_ram_dual_stream_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH/2-1:0]   out_data;
    logic [DEPTH+1:0]     level;
    logic                 ram_wr_en;
    logic [WIDTH-1:0]     ram_din;
    logic [DEPTH-1:0]     ram_writeAddr;
    logic [DEPTH:0]       ram_readAddr;
    logic [WIDTH/2-1:0]   ram_dout;

    int tests_run = 0;
    int tests_failed = 0;

    ram_dual_stream_ctrl #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .level        (level),
        .ram_wr_en    (ram_wr_en),
        .ram_din      (ram_din),
        .ram_writeAddr(ram_writeAddr),
        .ram_readAddr (ram_readAddr),
        .ram_dout     (ram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural ram_dual: word write port, registered halfword read port.
    logic [WIDTH-1:0] mem [2**DEPTH];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_writeAddr] <= ram_din;
        ram_dout <= ram_readAddr[0] ? mem[ram_readAddr[DEPTH:1]][WIDTH/2-1:0]
                                    : mem[ram_readAddr[DEPTH:1]][WIDTH-1:WIDTH/2];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input string tag, input logic [WIDTH-1:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        #1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_wr_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic take_half(input string tag, input logic [WIDTH/2-1:0] exp);
        int n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, out_valid, 1);
        check(tag, out_data, exp);
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0]   w;
        logic [WIDTH/2-1:0] e;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b0;

        // Reset held two cycles with a word offered
        tick(); tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_level", level, 0);
        check("rst_wr_en", ram_wr_en, 0);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("rel_in_ready", in_ready, 1);
        check("rel_level", level, 0);

        // Single word 0xA5
        write_word("sw", 8'hA5);
        check("sw_level_e0", level, 2);
        check("sw_valid_e0", out_valid, 0);
        tick();
        check("sw_valid_e1", out_valid, 0);
        check("sw_level_e1", level, 1);
        tick();
        check("sw_valid_e2", out_valid, 1);
        check("sw_hi_e2", out_data, 4'hA);
        take_half("sw_hi", 4'hA);
        take_half("sw_lo", 4'h5);
        check("sw_end_valid", out_valid, 0);
        check("sw_end_level", level, 0);

        // Fill: 16 words back to back with consumer stalled
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(i);
            #1;
            check("full_accept", in_ready, 1);
            tick();
        end
        in_valid = 1'b1;
        in_data  = 8'h10;
        #1;
        check("full_level", level, 31);
        check("full_in_ready", in_ready, 0);

        // Backpressure: HOLD stable for 10 cycles, 17th word stays blocked
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 0);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_drain_level", level, 30);
        check("bp_drain_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_w17_level", level, 32);
        check("bp_w17_ready", in_ready, 0);
        for (int h = 1; h < 34; h++) begin
            w = WIDTH'(h / 2);
            e = (h % 2 == 0) ? w[WIDTH-1:WIDTH/2] : w[WIDTH/2-1:0];
            take_half("full_seq", e);
        end
        tick();
        check("full_end_valid", out_valid, 0);
        check("full_end_level", level, 0);

        // Wrap-around: 40 words with random consumer stalls
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    write_word("wrap", WIDTH'(i));
                end
            end
            begin
                int got_n = 0;
                int cyc = 0;
                logic [WIDTH-1:0]   ww;
                logic [WIDTH/2-1:0] ee;
                while (got_n < 80 && cyc < 3000) begin
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        ww = WIDTH'(got_n / 2);
                        ee = (got_n % 2 == 0) ? ww[WIDTH-1:WIDTH/2] : ww[WIDTH/2-1:0];
                        check("wrap_seq", out_data, ee);
                        got_n++;
                    end
                    tick();
                    cyc++;
                end
                out_ready = 1'b0;
                check("wrap_count", got_n, 80);
            end
        join
        tick();
        check("wrap_end_valid", out_valid, 0);
        check("wrap_end_level", level, 0);

        // Flush while a read is pending in WAIT
        write_word("fl", 8'h11);
        write_word("fl", 8'h22);
        write_word("fl", 8'h33);
        take_half("fl_first", 4'h1);
        check("fl_in_wait", out_valid, 0);
        flush = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h99;
        #1;
        check("fl_in_ready", in_ready, 0);
        check("fl_wr_en", ram_wr_en, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_level", level, 0);
        check("fl_keep_data", out_data, 4'h1);
        tick(); tick(); tick();
        check("fl_discard", out_valid, 0);
        check("fl_level2", level, 0);
        write_word("fl2", 8'h3C);
        take_half("fl_hi", 4'h3);
        take_half("fl_lo", 4'hC);
        tick();
        check("fl_end_valid", out_valid, 0);
        check("fl_end_level", level, 0);

        // Reset mid-operation clears out_data as well
        write_word("mr", 8'hA5);
        tick(); tick();
        check("mr_hold_valid", out_valid, 1);
        check("mr_hold_data", out_data, 4'hA);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_data", out_data, 0);
        check("mr_valid", out_valid, 0);
        check("mr_level", level, 0);
        tick(); tick();
        check("mr_stay_idle", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
